// File: rtl/spi_monitor_pkg.sv
// Shared opcodes, FSM state encoding and payload-width helpers for the SPI bus monitor.
package spi_monitor_pkg;

    localparam logic [7:0] OP_READ_LIVE = 8'h01;
    localparam logic [7:0] OP_WRITE_SIG = 8'h02;
    localparam logic [7:0] OP_READ_CAPT = 8'h03;
    localparam logic [7:0] OP_STATUS    = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_TX,
        ST_RX,
        ST_IGNORE
    } state_t;

    function automatic int unsigned round8(input int unsigned n);
        return ((n + 7) / 8) * 8;
    endfunction

    function automatic int unsigned pw_bits(input int unsigned a, input int unsigned d,
                                            input int unsigned o);
        return round8(a + d + o);
    endfunction

    function automatic int unsigned iw_bits(input int unsigned i);
        return round8(i);
    endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// Snapshot FIFO with sticky overflow; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module snapshot_fifo #(
    parameter int unsigned W     = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_din,
    input  logic                         i_ovf_clr,
    output logic [W-1:0]                 o_head_c,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full_c,
    output logic                         o_empty_c,
    output logic                         o_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full_c  = (r_count == (AW+1)'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_do_push = i_push && (!o_full_c || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A dropped capture beats a simultaneous clear so no loss goes unreported.
            if (i_push && o_full_c && !w_do_pop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/spi_bus_monitor.sv
// SPI-slave debug monitor: oversampled mode-0 SPI, live/captured bus snapshot
// readout, status byte and host-written input signal bank.
module spi_bus_monitor
    import spi_monitor_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OSIG_W = 4,
    parameter int unsigned ISIG_W = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              CLK_IN,
    input  logic              RESET_IN,
    input  logic              SPICLK_IN,
    input  logic              SPISS_IN,
    input  logic              SPISI_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [OSIG_W-1:0] OUTPUT_SIGNAL_IN,
    input  logic              CAPTURE_IN,
    output logic [ISIG_W-1:0] INPUT_SIGNAL,
    output logic              SPISO,
    output logic              SPISO_OE
);

    localparam int unsigned PW  = pw_bits(ADDR_W, DATA_W, OSIG_W);
    localparam int unsigned IW  = iw_bits(ISIG_W);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned TCW = $clog2(PW + 1);
    localparam int unsigned RCW = $clog2(IW + 1);

    logic [1:0]        r_sclk_sync;
    logic [1:0]        r_ss_sync;
    logic [1:0]        r_si_sync;
    logic              r_sclk_d;
    logic              w_sclk;
    logic              w_ss;
    logic              w_si;
    logic              w_rise;
    logic              w_fall;

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_cmd;
    logic [7:0]        w_cmd_next;
    logic              w_cmd_done;
    logic [PW-1:0]     r_tx;
    logic [TCW-1:0]    r_tx_cnt;
    logic [TCW-1:0]    r_tx_len;
    logic [ISIG_W-1:0] r_rx;
    logic [ISIG_W-1:0] w_rx_mask;
    logic [ISIG_W-1:0] w_rx_next;
    logic [RCW-1:0]    r_rx_cnt;
    logic [ISIG_W-1:0] r_isig;
    logic              r_so;
    logic              r_oe;

    logic              w_pop;
    logic              w_ovf_clr;
    logic [PW-1:0]     w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf;

    // Two-flop synchronizers; SS idles high so its chain resets to 1.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_sclk_sync <= 2'b00;
            r_ss_sync   <= 2'b11;
            r_si_sync   <= 2'b00;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], SPICLK_IN};
            r_ss_sync   <= {r_ss_sync[0], SPISS_IN};
            r_si_sync   <= {r_si_sync[0], SPISI_IN};
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_sclk = r_sclk_sync[1];
    assign w_ss   = r_ss_sync[1];
    assign w_si   = r_si_sync[1];
    assign w_rise = w_sclk && !r_sclk_d;
    assign w_fall = !w_sclk && r_sclk_d;

    assign w_cmd_next = {w_si, r_cmd};
    assign w_cmd_done = !w_ss && (r_state == ST_CMD) && w_rise && (r_bit_cnt == 3'd7);
    assign w_pop      = w_cmd_done && (w_cmd_next == OP_READ_CAPT) && !w_empty;
    assign w_ovf_clr  = w_cmd_done && (w_cmd_next == OP_STATUS);

    // Bits beyond ISIG_W get an all-zero mask and are discarded.
    assign w_rx_mask = ISIG_W'(1) << r_rx_cnt;
    assign w_rx_next = w_si ? (r_rx | w_rx_mask) : (r_rx & ~w_rx_mask);

    snapshot_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK_IN),
        .rst       (RESET_IN),
        .i_push    (CAPTURE_IN),
        .i_pop     (w_pop),
        .i_din     (PW'({OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN})),
        .i_ovf_clr (w_ovf_clr),
        .o_head_c  (w_head),
        .o_count   (w_count),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_ovf     (w_ovf)
    );

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_tx_cnt  <= '0;
            r_tx_len  <= '0;
            r_rx      <= '0;
            r_rx_cnt  <= '0;
            r_isig    <= '0;
            r_so      <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_oe <= !w_ss;
            if (w_ss) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_cmd     <= '0;
                r_tx      <= '0;
                r_tx_cnt  <= '0;
                r_tx_len  <= '0;
                r_rx      <= '0;
                r_rx_cnt  <= '0;
                r_so      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_CMD;
                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd     <= w_cmd_next[7:1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        // Payload is latched on the same cycle the last command bit lands.
                        if (w_cmd_done) begin
                            case (w_cmd_next)
                                OP_READ_LIVE: begin
                                    r_tx     <= PW'({OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN});
                                    r_tx_len <= TCW'(PW);
                                    r_state  <= ST_TX;
                                end
                                OP_READ_CAPT: begin
                                    r_tx     <= w_empty ? '0 : w_head;
                                    r_tx_len <= TCW'(PW);
                                    r_state  <= ST_TX;
                                end
                                OP_STATUS: begin
                                    r_tx     <= PW'({w_ovf, 7'(w_count)});
                                    r_tx_len <= TCW'(8);
                                    r_state  <= ST_TX;
                                end
                                OP_WRITE_SIG: r_state <= ST_RX;
                                default:      r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_TX: begin
                        if (w_fall) begin
                            if (r_tx_cnt < r_tx_len) begin
                                r_so     <= r_tx[0];
                                r_tx     <= r_tx >> 1;
                                r_tx_cnt <= r_tx_cnt + TCW'(1);
                            end else begin
                                r_so <= 1'b0;
                            end
                        end
                    end
                    ST_RX: begin
                        if (w_rise && (r_rx_cnt < RCW'(IW))) begin
                            r_rx     <= w_rx_next;
                            r_rx_cnt <= r_rx_cnt + RCW'(1);
                            if (r_rx_cnt == RCW'(IW - 1)) begin
                                r_isig <= w_rx_next;
                            end
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign INPUT_SIGNAL = r_isig;
    assign SPISO        = r_so;
    assign SPISO_OE     = r_oe;

endmodule

// File: doc/spi_bus_monitor.md
# spi_bus_monitor

Parametrised SPI-slave debug monitor: a host reads live or captured bus snapshots (address, data, output signals) and writes a bank of input signals over a byte-oriented SPI protocol. It runs entirely in the system clock domain, oversamples the SPI pins, and holds a small snapshot FIFO filled by a capture strobe from the bus side. It sits between the CPU bus tap and the external debug header.

## Interface
Parameters:
- ADDR_W, 24, captured address width
- DATA_W, 16, captured data width
- OSIG_W, 4, captured output-signal width
- ISIG_W, 4, host-written input-signal width (1..16)
- DEPTH, 8, snapshot FIFO entries (power of two, 2..64)

Ports (one clock; reset is asynchronous and active-high):
- CLK_IN  in  1  system clock
- RESET_IN  in  1  asynchronous, active-high reset
- SPICLK_IN  in  1  SPI clock, mode 0, asynchronous to CLK_IN
- SPISS_IN  in  1  SPI select, active-low
- SPISI_IN  in  1  SPI data from host
- ADDR_IN  in  ADDR_W  bus address
- DATA_IN  in  DATA_W  bus data
- OUTPUT_SIGNAL_IN  in  OSIG_W  bus status signals
- CAPTURE_IN  in  1  push one snapshot per CLK cycle while high
- INPUT_SIGNAL  out  ISIG_W  host-written signals, registered
- SPISO  out  1  SPI data to host
- SPISO_OE  out  1  high while SPISS_IN is low (pad tristate control)

## Operation
- SPICLK_IN, SPISS_IN, SPISI_IN each pass a 2-flop synchronizer; SPICLK edges detected from synchronized value.
- All fields LSB first. Payload P = {zero pad, OSIG, DATA, ADDR}, ADDR in LSBs; PW = ADDR_W+DATA_W+OSIG_W rounded up to a multiple of 8. IW = ISIG_W rounded up to 8.
- Frame: command byte, then data phase. Opcodes: 0x01 READ_LIVE, 0x02 WRITE_SIG, 0x03 READ_CAPT, 0x04 STATUS; any other → IGNORE.
- States: IDLE (SS high) → CMD (8 rising edges) → TX (READ_LIVE, READ_CAPT, STATUS) / RX (WRITE_SIG) / IGNORE → IDLE on SS deassert.
- READ_LIVE: ADDR/DATA/OSIG sampled in the CLK cycle the 8th command bit is taken; PW bits shifted out.
- READ_CAPT: FIFO head loaded and popped at the same point; empty FIFO → all-zero payload, no pop.
- STATUS: 8 bits out, [7] overflow sticky, [6:0] FIFO count; overflow cleared when the byte is loaded.
- WRITE_SIG: after IW bits received, INPUT_SIGNAL <= low ISIG_W bits; further bits ignored. Partial write → INPUT_SIGNAL unchanged.
- After the defined TX length, SPISO = 0 until SS high. SPISO = 0 outside TX.
- FIFO: CAPTURE_IN high and not full → push. Full → entry dropped, overflow set. Push and pop in same cycle when full → both accepted, count unchanged, no overflow.
- SS deasserted mid-frame: return to IDLE, shift registers cleared; an already-made pop stays consumed.
- Reset: INPUT_SIGNAL 0, SPISO 0, SPISO_OE 0, FIFO empty, overflow 0, state IDLE.

## Timing
- SPICLK high and low phases each ≥ 4 CLK periods; SS setup to first SPICLK rise ≥ 4 CLK.
- Edge-detect latency: 3 CLK after the pin transition.
- Host samples SPISI-side data on rising edge. Monitor drives SPISO bit n within 3 CLK of the falling edge following the (8+n)-th rising edge. Bit 0 is driven after the 8th falling edge.
- SPISO_OE follows SPISS_IN with 3 CLK latency.
- INPUT_SIGNAL updates 1 CLK after the final RX bit is sampled.
- FIFO count visible to STATUS 1 CLK after a push.

## Structure
- Package spi_monitor_pkg: opcode constants, state enum, PW/IW width functions.
- Sub-module snapshot_fifo: DEPTH × PW registers, push/pop/count/full/empty, and overflow sticky with a clear input.
- Top module holds the synchronizers, the state machine, and the TX/RX shift registers.

## Test plan
- Default params, ADDR_IN=0x123456, DATA_IN=0xBEEF, OSIG=0xA, READ_LIVE → 48 bits read as 0x0ABEEF123456; then SPISO 0.
- WRITE_SIG with byte 0x0C → INPUT_SIGNAL=0xC. Repeat with SS dropped after 5 data bits → stays 0xC.
- Three CAPTURE_IN pulses with addresses 1, 2, 3 → READ_CAPT ×3 returns 1, 2, 3; fourth READ_CAPT returns 0; STATUS = 0x00.
- Ten pushes with DEPTH=8 → STATUS 0x88; second STATUS 0x08; READ_CAPT returns entries 1..8.
- Full FIFO, CAPTURE_IN high in the same cycle as READ_CAPT pop → count stays 8, no overflow.
- RESET_IN asserted mid-TX → SPISO 0, SPISO_OE 0, INPUT_SIGNAL 0, FIFO empty. Opcode 0x55 → SPISO 0 for the whole frame.
